// File: rtl/complex_result_serializer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | complex_result_serializer_pkg: shared FSM encodings and res_data fields   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package complex_result_serializer_pkg;

  localparam int TAG_W  = 4;
  localparam int IM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_RE   = 2'd2,
    ST_IM   = 2'd3
  } crs_state_e;

  // Field offsets scale with the operand width, so they are exposed as functions.
  function automatic int tag_lsb(input int data_width);
    return 4 * data_width;
  endfunction

  function automatic int re_lsb(input int data_width);
    return 2 * data_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/complex_result_serializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | complex_result_serializer_if: result input stream and beat output stream  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface complex_result_serializer_if
  import complex_result_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) ();

  logic                            res_val;
  logic                            res_ready;
  logic [4*DATA_WIDTH+TAG_W-1:0]   res_data;
  logic                            out_val;
  logic                            out_ready;
  logic [2*DATA_WIDTH-1:0]         out_data;
  logic                            out_last;
  logic [TAG_W-1:0]                out_tag;
  logic [$clog2(FIFO_DEPTH):0]     fifo_level;

  modport master (
    output res_val, res_data, out_ready,
    input  res_ready, out_val, out_data, out_last, out_tag, fifo_level
  );

  modport slave (
    input  res_val, res_data, out_ready,
    output res_ready, out_val, out_data, out_last, out_tag, fifo_level
  );

endinterface
`default_nettype wire

// File: rtl/complex_result_serializer_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crs_sync_fifo: synchronous FIFO with level, look-ahead read, sync clear   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module crs_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [WIDTH-1:0]         rd_data_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   level_nxt
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = c_aw + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_aw-1:0]  rd_ptr_nx;
  logic [c_lw-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full      = (level_q == c_lw'(DEPTH));
  assign empty     = (level_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign rd_ptr_nx = rd_ptr_q + 1'b1;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_nx;
      level_d = level_q + c_lw'(do_push) - c_lw'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data      = mem_q[rd_ptr_q];
  assign rd_data_next = mem_q[rd_ptr_nx];
  assign level        = level_q;
  assign level_nxt    = level_d;

endmodule
`default_nettype wire

// File: rtl/complex_result_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | complex_result_serializer: buffers {tag,re,im} results, emits re/im beats |
// | Optional header beat per result with CRS_TAG_BEAT_EN.    Rev 1.0          |
// +--------------------------------------------------------------------------+
module complex_result_serializer
  import complex_result_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       sw_rst,
  complex_result_serializer_if.slave bus
);

  localparam int c_part_w  = 2 * DATA_WIDTH;
  localparam int c_res_w   = 4 * DATA_WIDTH + TAG_W;
  localparam int c_lvl_w   = $clog2(FIFO_DEPTH) + 1;
  localparam int c_tag_lsb = tag_lsb(DATA_WIDTH);
  localparam int c_re_lsb  = re_lsb(DATA_WIDTH);

  logic [c_res_w-1:0]  head, head_next, src;
  logic [c_lvl_w-1:0]  level, level_nxt;
  logic                fifo_full, fifo_empty;
  logic                push, pop;

  crs_state_e          state_q, state_d, first_state;
  logic                out_val_q, out_val_d;
  logic [c_part_w-1:0] out_data_q, out_data_d, first_data;
  logic                out_last_q, out_last_d;
  logic [TAG_W-1:0]    out_tag_q, out_tag_d;
  logic                res_ready_q, res_ready_d;

  assign push = bus.res_val && res_ready_q && !fifo_full;

  crs_sync_fifo #(
    .WIDTH (c_res_w),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rstn         (rstn),
    .clr          (sw_rst),
    .push         (push),
    .wr_data      (bus.res_data),
    .pop          (pop),
    .rd_data      (head),
    .rd_data_next (head_next),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .level        (level),
    .level_nxt    (level_nxt)
  );

  // When the final beat of the head is accepted, the next result is already
  // one slot ahead, so it is loaded in the same cycle for gapless output.
  always_comb begin
    src = (state_q == ST_IM) ? head_next : head;
`ifdef CRS_TAG_BEAT_EN
    first_state = ST_HDR;
    first_data  = {{(c_part_w-TAG_W){1'b0}}, src[c_tag_lsb +: TAG_W]};
`else
    first_state = ST_RE;
    first_data  = src[c_re_lsb +: c_part_w];
`endif
  end

  always_comb begin
    state_d     = state_q;
    out_val_d   = out_val_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_tag_d   = out_tag_q;
    pop         = 1'b0;
    res_ready_d = (level_nxt != c_lvl_w'(FIFO_DEPTH));
    if (sw_rst) begin
      state_d    = ST_IDLE;
      out_val_d  = 1'b0;
      out_data_d = '0;
      out_last_d = 1'b0;
      out_tag_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_d    = first_state;
            out_val_d  = 1'b1;
            out_data_d = first_data;
            out_last_d = 1'b0;
            out_tag_d  = src[c_tag_lsb +: TAG_W];
          end
        end
        ST_HDR: begin
          if (bus.out_ready) begin
            state_d    = ST_RE;
            out_data_d = src[c_re_lsb +: c_part_w];
            out_last_d = 1'b0;
          end
        end
        ST_RE: begin
          if (bus.out_ready) begin
            state_d    = ST_IM;
            out_data_d = src[IM_LSB +: c_part_w];
            out_last_d = 1'b1;
          end
        end
        ST_IM: begin
          if (bus.out_ready) begin
            pop = 1'b1;
            if (level > c_lvl_w'(1)) begin
              state_d    = first_state;
              out_data_d = first_data;
              out_last_d = 1'b0;
              out_tag_d  = src[c_tag_lsb +: TAG_W];
            end else begin
              state_d    = ST_IDLE;
              out_val_d  = 1'b0;
              out_data_d = '0;
              out_last_d = 1'b0;
              out_tag_d  = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      out_val_q   <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_tag_q   <= '0;
      res_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_val_q   <= out_val_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_tag_q   <= out_tag_d;
      res_ready_q <= res_ready_d;
    end
  end

  assign bus.res_ready  = res_ready_q;
  assign bus.out_val    = out_val_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.fifo_level = level;

endmodule
`default_nettype wire

// File: tb/tb_complex_result_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_complex_result_serializer: model-checked bench, directed + random      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_complex_result_serializer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
`ifdef CRS_TAG_BEAT_EN
  localparam int BEATS = 3;
`else
  localparam int BEATS = 2;
`endif

  logic clk    = 1'b0;
  logic rstn   = 1'b0;
  logic sw_rst = 1'b0;

  always #5 clk = ~clk;

  complex_result_serializer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  complex_result_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .sw_rst (sw_rst),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [15:0] re;
    logic [15:0] im;
  } ent_t;

  // Reference: queue of stored results, beat index into the head, and whether
  // a beat is on offer (valid appears one edge after the queue becomes non-empty).
  ent_t        mq[$];
  int          bidx = 0;
  bit          pres = 1'b0;
  int          m_sz;
  bit          m_popped;
  logic [15:0] cap_data[$];
  logic        cap_last[$];
  logic [3:0]  cap_tag[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [15:0] beat_of(ent_t e, int b);
`ifdef CRS_TAG_BEAT_EN
    if (b == 0) return {12'h000, e.tag};
    if (b == 1) return e.re;
    return e.im;
`else
    if (b == 0) return e.re;
    return e.im;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn || sw_rst) begin
      mq.delete();
      bidx = 0;
      pres = 1'b0;
    end else begin
      m_sz     = mq.size();
      m_popped = 1'b0;
      if (pres && bus.out_ready) begin
        cap_data.push_back(bus.out_data);
        cap_last.push_back(bus.out_last);
        cap_tag.push_back(bus.out_tag);
        if (bidx == BEATS - 1) begin
          void'(mq.pop_front());
          bidx     = 0;
          m_popped = 1'b1;
        end else begin
          bidx++;
        end
      end
      if (pres) pres = !(m_popped && m_sz == 1);
      else      pres = (m_sz > 0);
      if (bus.res_val && m_sz != DEPTH)
        mq.push_back('{bus.res_data[35:32], bus.res_data[31:16], bus.res_data[15:0]});
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("level", 32'(bus.fifo_level), 32'(mq.size()));
      chk("res_ready", 32'(bus.res_ready), 32'(mq.size() != DEPTH));
      chk("out_val", 32'(bus.out_val), 32'(pres));
      if (pres && mq.size() > 0) begin
        chk("out_data", 32'(bus.out_data), 32'(beat_of(mq[0], bidx)));
        chk("out_last", 32'(bus.out_last), 32'(bidx == BEATS - 1));
        chk("out_tag", 32'(bus.out_tag), 32'(mq[0].tag));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(logic [3:0] t, logic [15:0] r, logic [15:0] i);
    bit acc;
    bit done = 1'b0;
    bus.res_val  = 1'b1;
    bus.res_data = {t, r, i};
    for (int k = 0; k < 200; k++) begin
      acc = bus.res_ready;
      step();
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    bus.res_val = 1'b0;
    if (!done) bound_fail("push_timeout");
  endtask

  task automatic drain();
    bit done = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (bus.fifo_level == 0 && !bus.out_val) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) bound_fail("drain_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    int          cnt;
    bit          ok;
    logic [15:0] exp_first;
    logic [15:0] res_re[4];
    logic [3:0]  tag_q[$];
    logic [63:0] rnd;

    bus.res_val   = 1'b0;
    bus.res_data  = '0;
    bus.out_ready = 1'b1;
    #23 rstn = 1'b1;
    step();

    // Reset values
    chk("rst_out_val", 32'(bus.out_val), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_level", 32'(bus.fifo_level), 32'd0);
    chk("rst_res_ready", 32'(bus.res_ready), 32'd1);

    // 1: single result, first beat one edge after the push edge
    c0 = cap_data.size();
    bus.res_val  = 1'b1;
    bus.res_data = {4'd2, 16'h0F1E, 16'h00A5};
    @(posedge clk);
    #1 bus.res_val = 1'b0;
    @(negedge clk);
    chk("t1_lat_n", 32'(bus.out_val), 32'd0);
    @(negedge clk);
    chk("t1_lat_n1", 32'(bus.out_val), 32'd1);
`ifdef CRS_TAG_BEAT_EN
    exp_first = 16'h0002;
`else
    exp_first = 16'h0F1E;
`endif
    chk("t1_first_data", 32'(bus.out_data), 32'(exp_first));
    #1;
    drain();
    chk("t1_nbeats", 32'(cap_data.size() - c0), 32'(BEATS));
    chk("t1_re", 32'(cap_data[c0+BEATS-2]), 32'h0F1E);
    chk("t1_re_last", 32'(cap_last[c0+BEATS-2]), 32'd0);
    chk("t1_im", 32'(cap_data[c0+BEATS-1]), 32'h00A5);
    chk("t1_im_last", 32'(cap_last[c0+BEATS-1]), 32'd1);
    chk("t1_tag_re", 32'(cap_tag[c0+BEATS-2]), 32'd2);
    chk("t1_tag_im", 32'(cap_tag[c0+BEATS-1]), 32'd2);
`ifdef CRS_TAG_BEAT_EN
    chk("t1_hdr", 32'(cap_data[c0]), 32'h0002);
`endif
    chk("t1_level_end", 32'(bus.fifo_level), 32'd0);

    // 2: fill under backpressure, ignored fifth, ordered release
    bus.out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      res_re[b] = 16'($urandom);
      push_one(4'(4 + b), res_re[b], 16'($urandom));
    end
    chk("t2_level_full", 32'(bus.fifo_level), 32'd4);
    chk("t2_ready_full", 32'(bus.res_ready), 32'd0);
    bus.res_val  = 1'b1;
    bus.res_data = {4'hF, 16'hDEAD, 16'hBEEF};
    repeat (3) step();
    bus.res_val = 1'b0;
    chk("t2_level_5th", 32'(bus.fifo_level), 32'd4);
    c0 = cap_data.size();
    bus.out_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bus.fifo_level == 3) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) chk("t2_ready_after_pop", 32'(bus.res_ready), 32'd1);
    else bound_fail("t2_wait_pop");
    drain();
    chk("t2_nbeats", 32'(cap_data.size() - c0), 32'(4 * BEATS));
    for (int b = 0; b < 4; b++) begin
      chk("t2_order_tag", 32'(cap_tag[c0+b*BEATS]), 32'(4 + b));
      chk("t2_order_re", 32'(cap_data[c0+b*BEATS+BEATS-2]), 32'(res_re[b]));
    end

    // 3: ready toggling every cycle while beats are on offer
    c0 = cap_data.size();
    bus.out_ready = 1'b0;
    push_one(4'd3, 16'h0F1E, 16'h1234);
    for (int k = 0; k < 20; k++) begin
      bus.out_ready = k[0];
      step();
    end
    drain();
    chk("t3_nbeats", 32'(cap_data.size() - c0), 32'(BEATS));
    chk("t3_re", 32'(cap_data[c0+BEATS-2]), 32'h0F1E);
    chk("t3_im", 32'(cap_data[c0+BEATS-1]), 32'h1234);

    // 4: push exactly on each final-beat handshake, level holds at 2 across wrap
    c0 = cap_data.size();
    tag_q.delete();
    bus.out_ready = 1'b0;
    push_one(4'd8, 16'h1111, 16'h2222);
    push_one(4'd9, 16'h3333, 16'h4444);
    tag_q.push_back(4'd8);
    tag_q.push_back(4'd9);
    bus.out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 200 && cnt < 12; k++) begin
      bus.res_val  = bus.out_val && bus.out_last;
      rnd          = {$urandom, $urandom};
      bus.res_data = {4'(cnt), rnd[31:0]};
      if (bus.res_val) tag_q.push_back(4'(cnt));
      chk("t4_level", 32'(bus.fifo_level), 32'd2);
      step();
      if (bus.res_val) cnt++;
    end
    bus.res_val = 1'b0;
    chk("t4_count", 32'(cnt), 32'd12);
    drain();
    for (int b = 0; b < tag_q.size(); b++)
      chk("t4_order", 32'(cap_tag[c0+b*BEATS]), 32'(tag_q[b]));

    // 5: synchronous clear while on the imaginary beat with 3 stored
    bus.out_ready = 1'b0;
    push_one(4'd1, 16'hA1A1, 16'hB1B1);
    push_one(4'd2, 16'hA2A2, 16'hB2B2);
    push_one(4'd3, 16'hA3A3, 16'hB3B3);
    bus.out_ready = 1'b1;
    repeat (BEATS - 1) step();
    bus.out_ready = 1'b0;
    chk("t5_in_im", 32'(bus.out_last), 32'd1);
    chk("t5_level3", 32'(bus.fifo_level), 32'd3);
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    chk("t5_val", 32'(bus.out_val), 32'd0);
    chk("t5_level", 32'(bus.fifo_level), 32'd0);
    chk("t5_ready", 32'(bus.res_ready), 32'd1);
    c0 = cap_data.size();
    bus.out_ready = 1'b1;
    push_one(4'hA, 16'hBEEF, 16'hCAFE);
    drain();
`ifdef CRS_TAG_BEAT_EN
    exp_first = 16'h000A;
`else
    exp_first = 16'hBEEF;
`endif
    chk("t5_first_after", 32'(cap_data[c0]), 32'(exp_first));
    chk("t5_nbeats", 32'(cap_data.size() - c0), 32'(BEATS));

    // 6: asynchronous reset between edges
    bus.out_ready = 1'b0;
    push_one(4'd5, 16'h5555, 16'h6666);
    push_one(4'd6, 16'h7777, 16'h8888);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("t6_val", 32'(bus.out_val), 32'd0);
    chk("t6_data", 32'(bus.out_data), 32'd0);
    chk("t6_last", 32'(bus.out_last), 32'd0);
    chk("t6_tag", 32'(bus.out_tag), 32'd0);
    chk("t6_level", 32'(bus.fifo_level), 32'd0);
    chk("t6_ready", 32'(bus.res_ready), 32'd1);
    @(posedge clk);
    #3 rstn = 1'b1;
    step();

    // Random traffic, including occasional synchronous clears
    for (int k = 0; k < 800; k++) begin
      rnd           = {$urandom, $urandom};
      bus.res_val   = rnd[40];
      bus.res_data  = rnd[35:0];
      bus.out_ready = (rnd[43:42] != 2'b00);
      sw_rst        = (rnd[50:45] == 6'd0);
      step();
    end
    sw_rst      = 1'b0;
    bus.res_val = 1'b0;
    drain();
    chk("end_level", 32'(bus.fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
